// File: rtl/ram_dp_clr_if.sv
// ram_dp_clr_if: write/read/clear bus of the dual-port clearable RAM.
interface ram_dp_clr_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 10
);
    logic                      clear_i;
    logic                      busy_o;
    logic                      write_en_i;
    logic [ADDRESS_WIDTH-1:0]  write_address_i;
    logic [DATA_WIDTH/8-1:0]   write_byte_en_i;
    logic [DATA_WIDTH-1:0]     data_i;
    logic                      read_en_i;
    logic [ADDRESS_WIDTH-1:0]  read_address_i;
    logic [DATA_WIDTH-1:0]     data_o;
    logic                      data_valid_o;

    modport master (
        output clear_i, write_en_i, write_address_i, write_byte_en_i, data_i, read_en_i, read_address_i,
        input  busy_o, data_o, data_valid_o
    );

    modport slave (
        input  clear_i, write_en_i, write_address_i, write_byte_en_i, data_i, read_en_i, read_address_i,
        output busy_o, data_o, data_valid_o
    );
endinterface

// File: rtl/ram_dp_clr.sv
// ram_dp_clr: dual-port RAM with byte enables, registered read and sweep clear.
// Define RAM_OUT_REG_EN for a second output register stage (read latency 2).
module ram_dp_clr #(
    parameter int                    DATA_WIDTH    = 32,
    parameter int                    ADDRESS_WIDTH = 10,
    parameter int                    RDW_MODE      = 0,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE   = '0
) (
    input logic         clk,
    input logic         rst,
    ram_dp_clr_if.slave bus
);
    localparam int LANES    = DATA_WIDTH / 8;
    localparam int MEM_SIZE = 2 ** ADDRESS_WIDTH;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                   state, state_nx;
    logic [ADDRESS_WIDTH-1:0] cnt, cnt_nx;
    logic [DATA_WIDTH-1:0]    mem [MEM_SIZE];
    logic [DATA_WIDTH-1:0]    rd_word, d1;
    logic                     v1, busy, wr_ok, rd_ok;

    assign busy  = state == CLEAR;
    assign wr_ok = !rst && !busy && bus.write_en_i;
    assign rd_ok = !rst && !busy && bus.read_en_i;
    assign bus.busy_o = busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (state == CLEAR) begin
            cnt_nx   = cnt + 1'b1;
            state_nx = &cnt ? IDLE : CLEAR;
        end else if (bus.clear_i) begin
            state_nx = CLEAR;
            cnt_nx   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (busy)
            mem[cnt] <= CLEAR_VALUE;
        else if (wr_ok)
            for (int k = 0; k < LANES; k++)
                if (bus.write_byte_en_i[k])
                    mem[bus.write_address_i][8*k +: 8] <= bus.data_i[8*k +: 8];
    end

    // RDW_MODE=1 forwards the enabled lanes of a same-address write into the read
    always_comb begin
        rd_word = mem[bus.read_address_i];
        for (int k = 0; k < LANES; k++)
            if (RDW_MODE == 1 && wr_ok && bus.write_byte_en_i[k] && bus.write_address_i == bus.read_address_i)
                rd_word[8*k +: 8] = bus.data_i[8*k +: 8];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d1 <= '0;
            v1 <= 1'b0;
        end else begin
            v1 <= rd_ok;
            if (rd_ok)
                d1 <= rd_word;
        end
    end

`ifdef RAM_OUT_REG_EN
    logic [DATA_WIDTH-1:0] d2;
    logic                  v2;

    always_ff @(posedge clk) begin
        if (rst) begin
            d2 <= '0;
            v2 <= 1'b0;
        end else begin
            v2 <= v1;
            if (v1)
                d2 <= d1;
        end
    end

    assign bus.data_o       = d2;
    assign bus.data_valid_o = v2;
`else
    assign bus.data_o       = d1;
    assign bus.data_valid_o = v1;
`endif
endmodule

// File: tb/tb_ram_dp_clr.sv
// tb_ram_dp_clr: table-driven bench with a read scoreboard for ram_dp_clr.
module tb_ram_dp_clr;
    localparam int          AW   = 4;
    localparam int          MEM  = 16;
    localparam int          RDW  = 0;
    localparam logic [31:0] CV   = 32'hDEADBEEF;
`ifdef RAM_OUT_REG_EN
    localparam int          LAT  = 2;
`else
    localparam int          LAT  = 1;
`endif

    typedef struct {
        logic          we;
        logic [AW-1:0] wa;
        logic [3:0]    be;
        logic [31:0]   d;
        logic          re;
        logic [AW-1:0] ra;
        logic [31:0]   ex;
    } vec_t;

    typedef struct {
        logic        v;
        logic [31:0] d;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   nvec = 0;
    int   nfail = 0;
    int   clr_left = 0;
    logic [31:0] hold = '0;
    exp_t exp_q[$];
    vec_t tbl[16];

    ram_dp_clr_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(AW)) bus ();

    ram_dp_clr #(
        .DATA_WIDTH(32), .ADDRESS_WIDTH(AW), .RDW_MODE(RDW), .CLEAR_VALUE(CV)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, %0d vectors", nvec);
        $fatal(1);
    end

    task automatic cyc(input logic clr, input logic we, input logic [AW-1:0] wa, input logic [3:0] be,
                       input logic [31:0] d, input logic re, input logic [AW-1:0] ra, input logic [31:0] ex);
        exp_t e;
        logic acc;
        acc = clr_left == 0;
        bus.clear_i         = clr;
        bus.write_en_i      = we;
        bus.write_address_i = wa;
        bus.write_byte_en_i = be;
        bus.data_i          = d;
        bus.read_en_i       = re;
        bus.read_address_i  = ra;
        exp_q.push_back('{re && acc, ex});
        if (clr_left > 0) clr_left--;
        else if (clr) clr_left = MEM;
        @(posedge clk);
        #1;
        bus.clear_i    = 1'b0;
        bus.write_en_i = 1'b0;
        bus.read_en_i  = 1'b0;
        nvec++;
        if (bus.busy_o !== (clr_left > 0)) begin
            nfail++;
            $display("FAIL busy: got %b want %b", bus.busy_o, clr_left > 0);
        end
        if (exp_q.size() >= LAT) begin
            e = exp_q.pop_front();
            if (e.v) hold = e.d;
            nvec++;
            if (bus.data_valid_o !== e.v || bus.data_o !== hold) begin
                nfail++;
                $display("FAIL read: got valid=%b data=%h want valid=%b data=%h", bus.data_valid_o, bus.data_o, e.v, hold);
            end
        end
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, '0, 4'h0, '0, 1'b0, '0, '0);
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [31:0] ex);
        cyc(1'b0, 1'b0, '0, 4'h0, '0, 1'b1, a, ex);
    endtask

    task automatic do_reset();
        bus.clear_i    = 1'b0;
        bus.write_en_i = 1'b0;
        bus.read_en_i  = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        hold = '0;
        clr_left = MEM;
        nvec++;
        if (bus.busy_o !== 1'b1 || bus.data_valid_o !== 1'b0 || bus.data_o !== 32'h0) begin
            nfail++;
            $display("FAIL reset: got busy=%b valid=%b data=%h want 1 0 0", bus.busy_o, bus.data_valid_o, bus.data_o);
        end
    endtask

    task automatic sweep_len();
        int n;
        n = 0;
        while (bus.busy_o === 1'b1 && n < 40) begin
            idle();
            n++;
        end
        nvec++;
        if (n != MEM) begin
            nfail++;
            $display("FAIL sweep_len: got %0d cycles want %0d", n, MEM);
        end
    endtask

    task automatic read_all(input logic [31:0] ex);
        for (int a = 0; a < MEM; a++) rd(AW'(a), ex);
        for (int i = 0; i < LAT; i++) idle();
    endtask

    initial begin
        tbl[0]  = '{1, 3,  4'hF, 32'hAABBCCDD, 0, 0,  0};
        tbl[1]  = '{1, 3,  4'h2, 32'h11223344, 0, 0,  0};
        tbl[2]  = '{0, 0,  4'h0, 32'h0,        1, 3,  32'hAABB33DD};
        tbl[3]  = '{1, 5,  4'hF, 32'h00000001, 0, 0,  0};
        tbl[4]  = '{1, 5,  4'h1, 32'h000000FF, 1, 5,  RDW == 1 ? 32'h000000FF : 32'h00000001};
        tbl[5]  = '{0, 0,  4'h0, 32'h0,        1, 5,  32'h000000FF};
        tbl[6]  = '{1, 7,  4'hC, 32'hCAFEF00D, 1, 6,  CV};
        tbl[7]  = '{1, 7,  4'h0, 32'h12345678, 1, 7,  32'hCAFEBEEF};
        tbl[8]  = '{0, 0,  4'h0, 32'h0,        1, 7,  32'hCAFEBEEF};
        tbl[9]  = '{1, 15, 4'hF, 32'h01020304, 1, 0,  CV};
        tbl[10] = '{0, 0,  4'h0, 32'h0,        1, 15, 32'h01020304};
        tbl[11] = '{1, 3,  4'h8, 32'hFF000000, 1, 3,  RDW == 1 ? 32'hFFBB33DD : 32'hAABB33DD};
        tbl[12] = '{0, 0,  4'h0, 32'h0,        1, 0,  CV};
        tbl[13] = '{0, 0,  4'h0, 32'h0,        1, 1,  CV};
        tbl[14] = '{0, 0,  4'h0, 32'h0,        1, 2,  CV};
        tbl[15] = '{0, 0,  4'h0, 32'h0,        1, 3,  32'hFFBB33DD};

        bus.clear_i = 1'b0; bus.write_en_i = 1'b0; bus.read_en_i = 1'b0;
        bus.write_address_i = '0; bus.read_address_i = '0; bus.write_byte_en_i = '0; bus.data_i = '0;
        repeat (2) @(posedge clk);
        #1;

        do_reset();
        sweep_len();
        read_all(CV);

        foreach (tbl[i])
            cyc(1'b0, tbl[i].we, tbl[i].wa, tbl[i].be, tbl[i].d, tbl[i].re, tbl[i].ra, tbl[i].ex);
        for (int i = 0; i < LAT; i++) idle();

        // access while clearing is dropped; in-flight read still completes
        cyc(1'b1, 1'b0, '0, 4'h0, '0, 1'b1, 4'd15, 32'h01020304);
        cyc(1'b0, 1'b1, 4'd2, 4'hF, 32'h12345678, 1'b1, 4'd2, 32'h12345678);
        cyc(1'b1, 1'b0, '0, 4'h0, '0, 1'b0, '0, '0);
        while (clr_left > 0) idle();
        rd(4'd2, CV);
        rd(4'd15, CV);
        for (int i = 0; i < LAT; i++) idle();

        // reset when the sweep counter sits at 9
        cyc(1'b1, 1'b0, '0, 4'h0, '0, 1'b0, '0, '0);
        repeat (9) idle();
        do_reset();
        sweep_len();
        read_all(CV);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
